// File: rtl/mode_1_pkg.sv
// mode_1_pkg: shared constants for the mode_1 run/finish signalling pair.
// Holds the FSM state encoding (common to encoder and decoder), the
// decoder error codes and the default run-length counter width.
package mode_1_pkg;

  // Default width of the run-length counter and len output.
  localparam int CNT_W_DEF = 8;

  // FSM state encoding, kept as plain constants so older code can reuse it.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  // Error codes latched on entry to ST_ERR.
  localparam logic [1:0] ERR_BOTH   = 2'd0; // r and f high together
  localparam logic [1:0] ERR_ORPHAN = 2'd1; // f with no preceding run
  localparam logic [1:0] ERR_DROP   = 2'd2; // r fell without an f
  localparam logic [1:0] ERR_GAP    = 2'd3; // activity in the quiet cycle

endpackage

// File: rtl/mode_1_len_hold.sv
// mode_1_len_hold: valid/ready output register for decoded run lengths.
//
// Valid/ready: a transfer happens on a rising edge where len_valid and
// len_ready are both high. len/len_sat stay stable while len_valid is high
// and len_ready is low, unless a new load overwrites them; an overwrite of
// an untransferred result sets the sticky lost flag.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   load                  capture load_len/load_sat this cycle
//   load_len, load_sat    result to capture
//   clr                   clears the sticky lost flag
//   len_ready             downstream accepts this cycle
//   len_valid, len, len_sat   held result
//   lost                  sticky overwrite flag
module mode_1_len_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_len,
  input  logic         load_sat,
  input  logic         clr,
  input  logic         len_ready,
  output logic         len_valid,
  output logic [W-1:0] len,
  output logic         len_sat,
  output logic         lost
);

  logic         valid_q, valid_d;
  logic [W-1:0] len_q, len_d;
  logic         sat_q, sat_d;
  logic         lost_q, lost_d;
  logic         overwrite;

  // A load while the old result is still waiting and not being taken.
  assign overwrite = load && valid_q && !len_ready;

  always_comb begin
    valid_d = valid_q;
    len_d   = len_q;
    sat_d   = sat_q;
    if (valid_q && len_ready) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      len_d   = load_len;
      sat_d   = load_sat;
    end
    if (clr)            lost_d = 1'b0;
    else if (overwrite) lost_d = 1'b1;
    else                lost_d = lost_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      len_q   <= '0;
      sat_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      len_q   <= len_d;
      sat_q   <= sat_d;
      lost_q  <= lost_d;
    end
  end

  assign len_valid = valid_q;
  assign len       = len_q;
  assign len_sat   = sat_q;
  assign lost      = lost_q;

endmodule

// File: rtl/mode_1_dec.sv
// mode_1_dec: receive-side decoder for the mode_1 run/finish pair.
// Measures each run of r in clock cycles, delivers the length over a
// valid/ready port and flags protocol violations (sticky err/err_code).
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   r, f              run level and one-cycle finish pulse from the encoder
//   clr               clears err/lost; leaves the ERR state
//   len_ready         downstream accepts len this cycle
//   len_valid, len, len_sat   decoded result (see mode_1_len_hold)
//   busy              state is RUN
//   err, err_code     sticky error flag and first error code
//   lost              sticky flag, unconsumed result overwritten
module mode_1_dec
  import mode_1_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r,
  input  logic             f,
  input  logic             clr,
  input  logic             len_ready,
  output logic             len_valid,
  output logic [CNT_W-1:0] len,
  output logic             len_sat,
  output logic             busy,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             lost
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             load;
  logic             enter_err;
  logic [1:0]       new_code;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    load      = 1'b0;
    enter_err = 1'b0;
    new_code  = ERR_BOTH;
    case (state_q)
      ST_IDLE: begin
        if (r && f) begin
          enter_err = 1'b1;
          new_code  = ERR_BOTH;
        end else if (f) begin
          enter_err = 1'b1;
          new_code  = ERR_ORPHAN;
        end else if (r) begin
          state_d = ST_RUN;
          cnt_d   = CNT_W'(1);
          sat_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (r && f) begin
          enter_err = 1'b1;
          new_code  = ERR_BOTH;
        end else if (r) begin
          // Hold at the maximum and remember that the run overflowed.
          if (cnt_q == CNT_MAX) sat_d = 1'b1;
          else                  cnt_d = cnt_q + 1'b1;
        end else if (f) begin
          state_d = ST_GAP;
          load    = 1'b1;
        end else begin
          enter_err = 1'b1;
          new_code  = ERR_DROP;
        end
      end
      ST_GAP: begin
        if (r || f) begin
          enter_err = 1'b1;
          new_code  = ERR_GAP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        // ERR: r/f ignored; only clr leaves.
        if (clr) state_d = ST_IDLE;
      end
    endcase

    // Partial count is thrown away on any error.
    if (enter_err) begin
      state_d = ST_ERR;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end

    // Entering ERR wins over a same-cycle clr so the error is never missed.
    err_d  = err_q;
    code_d = code_q;
    if (enter_err) begin
      err_d  = 1'b1;
      code_d = new_code;
    end else if (clr) begin
      err_d  = 1'b0;
    end

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_BOTH;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  mode_1_len_hold #(.W(CNT_W)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_len  (cnt_q),
    .load_sat  (sat_q),
    .clr       (clr),
    .len_ready (len_ready),
    .len_valid (len_valid),
    .len       (len),
    .len_sat   (len_sat),
    .lost      (lost)
  );

  assign busy     = busy_q;
  assign err      = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_mode_1_dec.sv
// tb_mode_1_dec: directed and randomized checks of mode_1_dec.
// Two instances share all inputs: CNT_W=8 (main) and CNT_W=4 (saturation).
module tb_mode_1_dec;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r = 1'b0, f = 1'b0, clr = 1'b0, len_ready = 1'b0;

  logic       v8, s8, b8, e8, l8;
  logic [7:0] len8;
  logic [1:0] c8;
  logic       v4, s4, b4, e4, l4;
  logic [3:0] len4;
  logic [1:0] c4;

  int errors = 0;
  int checks = 0;

  // Transaction-level reference: expected lengths waiting for transfer.
  logic [7:0] exp_q[$];
  bit         model_on = 0;
  bit         rand_ready = 0;
  bit         mvalid = 0;
  bit         mlost = 0;
  logic [7:0] cur_len = '0;

  mode_1_dec #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .r(r), .f(f), .clr(clr), .len_ready(len_ready),
    .len_valid(v8), .len(len8), .len_sat(s8), .busy(b8), .err(e8),
    .err_code(c8), .lost(l8)
  );

  mode_1_dec #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .r(r), .f(f), .clr(clr), .len_ready(len_ready),
    .len_valid(v4), .len(len4), .len_sat(s4), .busy(b4), .err(e4),
    .err_code(c4), .lost(l4)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Driver: apply r/f for one cycle; outputs are examined #1 after the edge.
  task automatic cyc(input logic r_i, input logic f_i);
    @(negedge clk);
    r = r_i;
    f = f_i;
    if (model_on) begin
      len_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mvalid && len_ready) begin
        chk("xfer_valid", 32'(v8), 32'd1);
        chk("xfer_len", 32'(len8), 32'(exp_q[0]));
        void'(exp_q.pop_front());
        mvalid = 0;
      end
      if (f_i) begin
        if (mvalid) begin
          void'(exp_q.pop_front());
          mlost = 1;
        end
        exp_q.push_back(cur_len);
        mvalid = 1;
      end
    end
    @(posedge clk);
    #1;
    if (model_on) begin
      chk("m_valid", 32'(v8), 32'(mvalid));
      chk("m_lost", 32'(l8), 32'(mlost));
      chk("m_busy", 32'(b8), 32'(r_i));
      chk("m_err", 32'(e8), 32'd0);
    end
  endtask

  task automatic run_n(input int n);
    repeat (n) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
  endtask

  // Apply one violation (by its expected code), then recover with clr.
  task automatic violation(input logic [1:0] code);
    case (code)
      2'd0: cyc(1'b1, 1'b1);
      2'd1: cyc(1'b0, 1'b1);
      2'd2: begin cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); end
      default: begin cyc(1'b1, 1'b0); cyc(1'b0, 1'b1); cyc(1'b1, 1'b0); end
    endcase
    chk("viol_err", 32'(e8), 32'd1);
    chk("viol_code", 32'(c8), 32'(code));
    chk("viol_busy", 32'(b8), 32'd0);
    // r/f are ignored while in ERR.
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    chk("err_hold", 32'(e8), 32'd1);
    chk("err_code_hold", 32'(c8), 32'(code));
    chk("err_nobusy", 32'(b8), 32'd0);
    // clr overrides a simultaneous r: must return to IDLE, not RUN.
    clr = 1'b1;
    cyc(1'b1, 1'b0);
    clr = 1'b0;
    chk("clr_err", 32'(e8), 32'd0);
    chk("clr_idle", 32'(b8), 32'd0);
    run_n(2);
    chk("post_len", 32'(len8), 32'd2);
    chk("post_valid", 32'(v8), 32'd1);
    chk("post_err", 32'(e8), 32'd0);
    cyc(1'b0, 1'b0);
  endtask

  initial begin
    int n;
    // Reset state
    #12;
    chk("rst_valid", 32'(v8), 32'd0);
    chk("rst_len", 32'(len8), 32'd0);
    chk("rst_busy", 32'(b8), 32'd0);
    chk("rst_err", 32'(e8), 32'd0);
    chk("rst_lost", 32'(l8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    len_ready = 1'b1;

    // Run of 3 with ready high
    cyc(1'b1, 1'b0);
    chk("r3_busy", 32'(b8), 32'd1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("r3_novalid", 32'(v8), 32'd0);
    cyc(1'b0, 1'b1);
    chk("r3_valid", 32'(v8), 32'd1);
    chk("r3_len", 32'(len8), 32'd3);
    chk("r3_sat", 32'(s8), 32'd0);
    chk("r3_busy_off", 32'(b8), 32'd0);
    chk("r3_err", 32'(e8), 32'd0);
    cyc(1'b0, 1'b0);
    chk("r3_valid_1cyc", 32'(v8), 32'd0);

    // Back-to-back minimum runs
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      chk("b2b_len", 32'(len8), 32'd1);
      chk("b2b_valid", 32'(v8), 32'd1);
      chk("b2b_lost", 32'(l8), 32'd0);
      cyc(1'b0, 1'b0);
    end
    chk("b2b_err", 32'(e8), 32'd0);

    // Overwrite with ready low
    len_ready = 1'b0;
    run_n(2);
    chk("ow_len2", 32'(len8), 32'd2);
    cyc(1'b0, 1'b0);
    chk("ow_hold", 32'(len8), 32'd2);
    run_n(4);
    chk("ow_len4", 32'(len8), 32'd4);
    chk("ow_lost", 32'(l8), 32'd1);
    cyc(1'b0, 1'b0);
    clr = 1'b1;
    cyc(1'b0, 1'b0);
    clr = 1'b0;
    chk("ow_clr_lost", 32'(l8), 32'd0);
    chk("ow_clr_valid", 32'(v8), 32'd1);
    chk("ow_clr_len", 32'(len8), 32'd4);
    len_ready = 1'b1;
    cyc(1'b0, 1'b0);
    chk("ow_drain", 32'(v8), 32'd0);

    // Saturation on the CNT_W=4 instance
    run_n(20);
    chk("sat4_len", 32'(len4), 32'd15);
    chk("sat4_sat", 32'(s4), 32'd1);
    chk("sat8_len", 32'(len8), 32'd20);
    chk("sat8_sat", 32'(s8), 32'd0);
    cyc(1'b0, 1'b0);
    run_n(15);
    chk("max4_len", 32'(len4), 32'd15);
    chk("max4_nosat", 32'(s4), 32'd0);
    cyc(1'b0, 1'b0);

    // Protocol violations
    violation(2'd1);
    violation(2'd0);
    violation(2'd2);
    violation(2'd3);

    // Reset mid-run with a pending result and lost set
    len_ready = 1'b0;
    run_n(1);
    cyc(1'b0, 1'b0);
    run_n(1);
    cyc(1'b0, 1'b0);
    chk("pre_rst_lost", 32'(l8), 32'd1);
    repeat (4) cyc(1'b1, 1'b0);
    @(negedge clk);
    r = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_valid", 32'(v8), 32'd0);
    chk("mrst_len", 32'(len8), 32'd0);
    chk("mrst_sat", 32'(s8), 32'd0);
    chk("mrst_busy", 32'(b8), 32'd0);
    chk("mrst_err", 32'(e8), 32'd0);
    chk("mrst_code", 32'(c8), 32'd0);
    chk("mrst_lost", 32'(l8), 32'd0);
    @(negedge clk);
    r = 1'b0;
    rst_n = 1'b1;
    len_ready = 1'b1;
    run_n(2);
    chk("arst_len", 32'(len8), 32'd2);
    chk("arst_valid", 32'(v8), 32'd1);
    cyc(1'b0, 1'b0);

    // Randomized legal traffic against the transaction model
    model_on = 1;
    rand_ready = 1;
    mvalid = 0;
    mlost = 0;
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(1, 20);
      cur_len = 8'(n);
      run_n(n);
      cyc(1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0);
    end
    rand_ready = 0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    model_on = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mode_1_dec.md
# mode_1_dec

Receive-side decoder for the mode_1 run/finish signalling pair. It samples the registered `r` (run level) and `f` (one-cycle finish pulse) produced by the mode_1 encoder and measures each run's length in clock cycles. It delivers each length over a valid/ready port and flags any protocol violation on the pair. It sits at the consumer end of the link, clocked on the same `clk` as the encoder.

## Interface
- `CNT_W`, default 8: width of the run-length counter and the `len` output.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `r`  in  1  run level from the encoder; high for each cycle of a run.
- `f`  in  1  finish pulse from the encoder; high for 1 cycle directly after `r` falls.
- `clr`  in  1  synchronous clear of the sticky `err` and `lost` flags; also leaves the ERR state.
- `len_ready`  in  1  downstream accepts `len` on this cycle.
- `len_valid`  out  1  `len` and `len_sat` hold a result.
- `len`  out  CNT_W  run length in cycles; equals the number of cycles `r` was high.
- `len_sat`  out  1  the counter saturated during this run.
- `busy`  out  1  decoder is in RUN.
- `err`  out  1  sticky protocol-error flag.
- `err_code`  out  2  first error seen: 0 BOTH, 1 ORPHAN, 2 DROP, 3 GAP.
- `lost`  out  1  sticky flag; an unconsumed result was overwritten.

## Operation
- States are IDLE, RUN, GAP and ERR. The legal sequence is IDLE, then `r` high for N≥1 cycles, then `f` for 1 cycle, then 1 quiet cycle.
- IDLE:
  - `r&f` goes to ERR with BOTH.
  - `f` goes to ERR with ORPHAN.
  - `r` goes to RUN and sets cnt=1.
  - Otherwise the decoder stays in IDLE.
- RUN:
  - `r&f` goes to ERR with BOTH.
  - `r` stays in RUN; cnt increments and saturates at 2^CNT_W-1, setting the internal sat bit.
  - `f` goes to GAP and loads the result.
  - `!r&!f` goes to ERR with DROP.
- GAP: `r|f` goes to ERR with GAP. Otherwise the decoder goes to IDLE.
- ERR:
  - Inputs `r` and `f` are ignored.
  - The partial count is discarded and no result is emitted.
  - `clr` goes to IDLE; it overrides `r`/`f` on that cycle.
- Entering ERR sets `err`=1 and latches `err_code`. Both hold until `clr`. `clr` also clears `lost`. In non-ERR states `clr` affects only the flags.
- Result load happens on the `f` cycle in RUN:
  - `len` is loaded from cnt, `len_sat` from the sat bit, and `len_valid` is set to 1.
  - If `len_valid&!len_ready` on the load cycle, the old result is overwritten and `lost` is set to 1.
  - If `len_ready` is high on the load cycle, the old result counts as transferred and `lost` is unchanged.
- Handshake:
  - A transfer occurs on `len_valid&len_ready`.
  - `len_valid` clears after a transfer unless a load occurs in the same cycle.
  - `len` is stable while `len_valid&!len_ready`, except when overwritten.
- `busy` is 1 exactly while the state is RUN.

## Timing
- All outputs are registered. Reset values: `len_valid`=0, `len`=0, `len_sat`=0, `busy`=0, `err`=0, `err_code`=0, `lost`=0. State resets to IDLE and cnt to 0.
- `r` first high in cycle t: `busy`=1 from t+1.
- `f` high in cycle t: `len_valid`=1, `busy`=0 from t+1.
- Error condition in cycle t: `err`=1 from t+1.
- Minimum legal spacing between two `f` pulses is 3 cycles (f, gap, r, f). The result path sustains this rate with `len_ready` held high.
- Reset asserted mid-run: the run is abandoned and the state returns to IDLE. A pending result and all flags are lost.

## Structure
- Package `mode_1_pkg` holds:
  - the state encoding (IDLE=0, RUN=1, GAP=2, ERR=3);
  - the err-code constants ERR_BOTH, ERR_ORPHAN, ERR_DROP, ERR_GAP;
  - the default CNT_W.
- The encoder shares this package for its state encoding.
- One natural sub-module is `mode_1_len_hold`, the valid/ready output holding register with overwrite detection. The FSM and the saturating counter stay in `mode_1_dec`.

## Test plan
- Run of 3 cycles: `r`=1 for 3 cycles, then `f` for 1 cycle, with `len_ready`=1. Expect `len`=3, `len_valid`=1 for 1 cycle, `len_sat`=0, `err`=0.
- Back-to-back minimum runs of length 1 at the 3-cycle spacing with `len_ready`=1. Expect each `len`=1 and `lost`=0.
- Two runs, of length 2 and then 4, with `len_ready`=0. Expect `len`=4 and `lost`=1. After `clr`, expect `lost`=0 while `len_valid` stays 1.
- CNT_W=4 with `r` high for 20 cycles, then `f`. Expect `len`=15 and `len_sat`=1.
- Each violation applied in turn, expecting `err`=1 and the listed code. After `clr`, expect IDLE, `err`=0, and a following legal run decoded correctly.
  - `f` alone in IDLE: code 1.
  - `r&f`: code 0.
  - `r` drops without `f`: code 2.
  - `r` directly after `f`: code 3.
- `rst_n` low during the 5th cycle of a run. Expect all outputs 0. After release, a run of length 2 yields `len`=2.
